// File: rtl/divf_seq.sv
// ---------------------------------------------------------------------------
// divf_seq : sequential IEEE-754 single-precision divider, q = a / b.
//
// The mantissa quotient comes from restoring division, one bit per clock.
// Latency is fixed (start accepted in cycle 0, done in cycle 28) so that a
// sequencer can schedule results without polling. Subnormal inputs are read
// as signed zero and subnormal results are flushed to signed zero.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request, sampled only while busy=0 (IDLE or DONE)
//   a, b      in   dividend / divisor, latched on the accepting edge
//   busy      out  operation in progress (PREP and DIV states)
//   done      out  one-cycle pulse; q/flags are valid from this cycle
//   q         out  quotient, held until the next done
//   flags     out  {invalid, div_by_zero, overflow, underflow}, held with q
//   dbg_state out  current FSM state, for checkers
//
// Handshake: start=1 while busy=0 is an accepted request. There is no
// queueing; a start seen while busy=1 is dropped. A start in the done cycle
// is accepted, giving back-to-back issue every 28 cycles.
// ---------------------------------------------------------------------------
module divf_seq #(
    parameter int RND = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [3:0]  flags,
    output logic [1:0]  dbg_state
);

    localparam int LAT = 28;
    // Cycle 0 accepts, cycle 1 is PREP, cycles 2..27 are the 26 DIV steps,
    // cycle 28 is DONE. The counter value of the final DIV step:
    localparam logic [4:0] DIV_LAST = 5'(LAT - 3);

    // Rounding and packing happen on the edge that leaves the last DIV step,
    // so the NORM work is folded into that transition rather than taking a
    // cycle of its own; this keeps the 28-cycle latency.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [1:0]        r_state;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [24:0]       r_rem;
    logic [23:0]       r_mb;
    logic [24:0]       r_quo;
    logic [4:0]        r_cnt;
    logic              r_spec;
    logic [31:0]       r_spec_q;
    logic [3:0]        r_spec_f;
    logic [31:0]       r_q;
    logic [3:0]        r_flags;

    // ---------------- operand classification (from latched a/b) ----------
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_fa, w_fb;
    logic        w_a_zero, w_a_inf, w_a_nan, w_a_snan;
    logic        w_b_zero, w_b_inf, w_b_nan, w_b_snan;
    logic        w_sign;
    logic        w_spec;
    logic [31:0] w_spec_q;
    logic [3:0]  w_spec_f;

    always_comb begin
        w_ea     = r_a[30:23];
        w_eb     = r_b[30:23];
        w_fa     = r_a[22:0];
        w_fb     = r_b[22:0];
        w_sign   = r_a[31] ^ r_b[31];
        // Exponent 0 covers both true zero and subnormals (flush-to-zero).
        w_a_zero = (w_ea == 8'h00);
        w_b_zero = (w_eb == 8'h00);
        w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
        w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
        w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
        w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
        w_a_snan = w_a_nan && !w_fa[22];
        w_b_snan = w_b_nan && !w_fb[22];

        w_spec   = 1'b1;
        w_spec_q = 32'd0;
        w_spec_f = 4'd0;
        if (w_a_nan || w_b_nan) begin
            w_spec_q = QNAN;
            w_spec_f = {(w_a_snan || w_b_snan), 3'b000};
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_q = QNAN;
            w_spec_f = 4'b1000;
        end else if (w_b_zero) begin
            // Infinite dividend over zero is an exact infinity, not a div-by-zero.
            w_spec_q = {w_sign, 8'hFF, 23'd0};
            w_spec_f = {1'b0, !w_a_inf, 2'b00};
        end else if (w_a_inf) begin
            w_spec_q = {w_sign, 8'hFF, 23'd0};
        end else if (w_b_inf || w_a_zero) begin
            w_spec_q = {w_sign, 31'd0};
        end else begin
            w_spec   = 1'b0;
        end
    end

    // ---------------- one restoring-division step -------------------------
    // The remainder stays below 2*mb, so a single compare/subtract per cycle
    // yields one quotient bit; the first bit produced has weight 2^25.
    logic        w_ge;
    logic [24:0] w_rem_sub;
    logic [25:0] w_quo;

    always_comb begin
        w_ge      = (r_rem >= {1'b0, r_mb});
        w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
        w_quo     = {r_quo, w_ge};
    end

    // ---------------- normalise, round, pack (final DIV step) -------------
    logic [22:0]       w_frac;
    logic              w_guard;
    logic              w_sticky;
    logic              w_lsb;
    logic              w_inc;
    logic [23:0]       w_frac_inc;
    logic signed [9:0] w_exp1;
    logic signed [9:0] w_exp2;
    logic [31:0]       w_res_q;
    logic [3:0]        w_res_f;

    always_comb begin
        // The hidden bit is implied by w_quo[25] or w_quo[24]; only the
        // fraction below it is carried forward.
        if (w_quo[25]) begin
            w_frac   = w_quo[24:2];
            w_guard  = w_quo[1];
            w_sticky = w_quo[0] | (w_rem_sub != 25'd0);
            w_exp1   = r_exp;
        end else begin
            w_frac   = w_quo[23:1];
            w_guard  = w_quo[0];
            w_sticky = (w_rem_sub != 25'd0);
            w_exp1   = r_exp - 10'sd1;
        end
        w_lsb      = w_frac[0];
        w_inc      = (RND != 0) && w_guard && (w_sticky || w_lsb);
        // A carry out of the fraction means 1.111..1 rounded to 10.0: the
        // fraction wraps to zero and the exponent bumps by one.
        w_frac_inc = {1'b0, w_frac} + {23'd0, w_inc};
        w_exp2     = w_exp1 + {9'd0, w_frac_inc[23]};

        w_res_q = {r_sign, w_exp2[7:0], w_frac_inc[22:0]};
        w_res_f = 4'd0;
        if (r_spec) begin
            w_res_q = r_spec_q;
            w_res_f = r_spec_f;
        end else if (w_exp2 >= 10'sd255) begin
            w_res_q = (RND != 0) ? {r_sign, 8'hFF, 23'd0} : {r_sign, 31'h7F7F_FFFF};
            w_res_f = 4'b0010;
        end else if (w_exp2 <= 10'sd0) begin
            w_res_q = {r_sign, 31'd0};
            w_res_f = 4'b0001;
        end
    end

    // ---------------- control and datapath registers ----------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_sign   <= 1'b0;
            r_exp    <= 10'sd0;
            r_rem    <= 25'd0;
            r_mb     <= 24'd0;
            r_quo    <= 25'd0;
            r_cnt    <= 5'd0;
            r_spec   <= 1'b0;
            r_spec_q <= 32'd0;
            r_spec_f <= 4'd0;
            r_q      <= 32'd0;
            r_flags  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_state <= S_PREP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    r_sign   <= w_sign;
                    r_exp    <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;
                    r_rem    <= {2'b01, w_fa};
                    r_mb     <= {1'b1, w_fb};
                    r_quo    <= 25'd0;
                    r_cnt    <= 5'd0;
                    r_spec   <= w_spec;
                    r_spec_q <= w_spec_q;
                    r_spec_f <= w_spec_f;
                    r_state  <= S_DIV;
                end
                S_DIV: begin
                    r_rem <= {w_rem_sub[23:0], 1'b0};
                    r_quo <= w_quo[24:0];
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == DIV_LAST) begin
                        r_q     <= w_res_q;
                        r_flags <= w_res_f;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == S_PREP) || (r_state == S_DIV);
    assign done      = (r_state == S_DONE);
    assign q         = r_q;
    assign flags     = r_flags;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_divf_seq.sv
// ---------------------------------------------------------------------------
// tb_divf_seq : directed bench for divf_seq.
// Two instances share operands: dut (RND=1) and dut_t (RND=0, started only
// for the vectors where truncation is of interest). Drivers push expected
// {q, flags} into per-instance queues; monitors pop and compare on done.
// ---------------------------------------------------------------------------
module tb_divf_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start_t;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy, busy_t;
    logic        done, done_t;
    logic [31:0] q, q_t;
    logic [3:0]  flags, flags_t;
    logic [1:0]  st, st_t;

    int checks;
    int failures;

    logic [35:0] exp_q[$];
    logic [35:0] exp_t_q[$];

    divf_seq #(.RND(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .flags(flags), .dbg_state(st)
    );

    divf_seq #(.RND(0)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start_t), .a(a), .b(b),
        .busy(busy_t), .done(done_t), .q(q_t), .flags(flags_t), .dbg_state(st_t)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done q=%h flags=%b required=no done", q, flags);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({q, flags} !== e) begin
                    failures++;
                    $display("FAIL result_rne q=%h flags=%b required q=%h flags=%b",
                             q, flags, e[35:4], e[3:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done_t) begin
            checks++;
            if (exp_t_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done_trunc q=%h flags=%b required=no done", q_t, flags_t);
            end else begin
                logic [35:0] e;
                e = exp_t_q.pop_front();
                if ({q_t, flags_t} !== e) begin
                    failures++;
                    $display("FAIL result_trunc q=%h flags=%b required q=%h flags=%b",
                             q_t, flags_t, e[35:4], e[3:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call at a negedge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] eq, input logic [3:0] ef,
                         input logic use_t, input logic [31:0] eq_t,
                         input logic [3:0] ef_t);
        a       = va;
        b       = vb;
        start   = 1'b1;
        start_t = use_t;
        exp_q.push_back({eq, ef});
        if (use_t) exp_t_q.push_back({eq_t, ef_t});
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_t = 1'b0;
        // Operands must have been latched; scramble them.
        a = $urandom;
        b = $urandom;
    endtask

    // Waits for done (bounded); checks latency and busy profile. With inj=1,
    // start is pulsed in cycles 5 and 20 with junk operands. With hold=1,
    // q must equal hold_q in every cycle before done.
    // Returns at the negedge of the done cycle.
    task automatic wait_done(input string name, input logic inj,
                             input logic hold, input logic [31:0] hold_q);
        int lat;
        int busy_err;
        int hold_err;
        lat      = 0;
        busy_err = 0;
        hold_err = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 28 && busy !== (k < 28)) busy_err++;
            if (hold && k < 28 && q !== hold_q) hold_err++;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (inj && (k == 5 || k == 20)) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (lat != 28) begin
            failures++;
            $display("FAIL latency_%s got=%0d required=28", name, lat);
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL busy_profile_%s bad_cycles=%0d required=0", name, busy_err);
        end
        if (hold) begin
            checks++;
            if (hold_err != 0) begin
                failures++;
                $display("FAIL q_hold_%s bad_cycles=%0d required=0", name, hold_err);
            end
        end
    endtask

    task automatic op(input string name, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] eq, input logic [3:0] ef);
        issue(va, vb, eq, ef, 1'b0, 32'd0, 4'd0);
        wait_done(name, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        start_t  = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        #3;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_q", q, 32'd0);
        chk("reset_flags", {28'd0, flags}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Exact 15/3
        op("exact_15_3", 32'h4170_0000, 32'h4040_0000, 32'h40A0_0000, 4'b0000);

        // 1/3 on both rounding modes
        issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000,
              1'b1, 32'h3EAA_AAAA, 4'b0000);
        wait_done("one_third", 1'b0, 1'b0, 32'd0);
        @(negedge clk);

        op("neg_5_m1",   32'h40A0_0000, 32'hBF80_0000, 32'hC0A0_0000, 4'b0000);
        op("one_by_zero",32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100);
        op("zero_zero",  32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000);
        op("mzero_5",    32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 4'b0000);
        op("inf_2",      32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0000);
        op("inf_inf",    32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000);
        op("inf_zero",   32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0000);
        op("two_inf",    32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000);
        op("snan",       32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000);
        op("qnan",       32'h3F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 4'b0000);

        // Overflow: infinity with RNE, max finite with truncation
        issue(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b0010,
              1'b1, 32'h7F7F_FFFF, 4'b0010);
        wait_done("overflow", 1'b0, 1'b0, 32'd0);
        @(negedge clk);

        op("underflow",  32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001);
        op("subnormal",  32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000);

        // Starts while busy are ignored: exactly one done
        issue(32'h4170_0000, 32'h4040_0000, 32'h40A0_0000, 4'b0000, 1'b0, 32'd0, 4'd0);
        wait_done("ignored_starts", 1'b1, 1'b0, 32'd0);
        repeat (35) @(negedge clk);

        // Back-to-back: second start in the done cycle; q holds first result
        issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 1'b0, 32'd0, 4'd0);
        wait_done("b2b_first", 1'b0, 1'b0, 32'd0);
        issue(32'h40A0_0000, 32'hBF80_0000, 32'hC0A0_0000, 4'b0000, 1'b0, 32'd0, 4'd0);
        wait_done("b2b_second", 1'b0, 1'b1, 32'h3EAA_AAAB);
        @(negedge clk);

        // Asynchronous reset in cycle 10 abandons the operation
        issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 1'b0, 32'd0, 4'd0);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_t_q.delete();
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_q", q, 32'd0);
        chk("async_rst_flags", {28'd0, flags}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Any done in this window is reported by the monitor as unexpected.
        repeat (40) @(negedge clk);
        chk("post_rst_q_idle", q, 32'd0);

        op("after_reset", 32'h4170_0000, 32'h4040_0000, 32'h40A0_0000, 4'b0000);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("queue_t_empty", exp_t_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout reached required=finish before bound");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule

// File: doc/divf_seq.md
Name: divf_seq

Overview:
Sequential IEEE-754 single-precision divider, q = a / b. It complements the combinational `mulf` in the float unit.
- Mantissa quotient: restoring division, one bit per clock.
- Latency: fixed, so the ALU sequencer can schedule it without polling.
- Handshake: start/busy/done.
- Subnormal handling: flush-to-zero on both inputs and outputs.

Parameters:
RND, 1, rounding mode: 1 = round-to-nearest-even, 0 = truncate toward zero
LAT, 28, fixed cycles from start to done. Not overridable; exposed for benches only.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  32  dividend, IEEE-754 single
b  input  32  divisor, IEEE-754 single
busy  output  1  operation in progress
done  output  1  one-cycle pulse; q/flags valid from this cycle
q  output  32  quotient; held until the next done
flags  output  4  {invalid, div_by_zero, overflow, underflow}; held with q

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low. While rst_n=0: busy=0, done=0, q=0, flags=0, state=IDLE, internal registers cleared.
- Reset mid-operation: the operation is abandoned and no done is produced.

Handshake:
- start=1 with busy=0 at a rising edge (cycle 0) latches a and b. Later changes to a/b are ignored.
- busy=1 in cycles 1..27. done=1 and busy=0 in cycle 28.
- start while busy=1 is ignored (no queueing).
- start in the done cycle is accepted, giving back-to-back operation every 28 cycles.

States:
- IDLE -> PREP on accepted start.
- PREP (1 cycle): unpack, classify, set sign = sa^sb, exp_tmp = ea - eb + 127 (10-bit signed), ma/mb = {1,frac}.
- DIV (26 cycles): restoring division producing Q[25:0] = floor(ma·2^25 / mb), remainder r.
- NORM: round and pack.
- DONE: 1 cycle, then IDLE.
- Special-case operands still traverse all states; the result is overridden in NORM. Latency is therefore constant.

Normalisation and rounding:
- If Q[25]=1: mant = Q[25:2], guard = Q[1], sticky = Q[0] | (r≠0).
- Else: mant = Q[24:1], guard = Q[0], sticky = (r≠0), exp_tmp -= 1.
- RND=1: increment if guard & (sticky | mant[0]). On mantissa carry-out, mant = 1.0 and exp_tmp += 1.
- exp_tmp ≥ 255: overflow. q = signed inf (RND=1) or signed 0x7F7FFFFF (RND=0); overflow=1.
- exp_tmp ≤ 0: underflow. q = signed zero; underflow=1 (flush, no subnormal output).

Special cases (any exponent-0 input is treated as signed zero):
- Either input NaN: q = 0x7FC00000, invalid=1 only if the NaN is signalling.
- 0/0 or inf/inf: q = 0x7FC00000, invalid=1.
- Nonzero (finite or inf) / 0: q = signed inf, div_by_zero=1 only for a finite dividend.
- inf / finite: q = signed inf.
- Finite / inf, or 0 / nonzero: q = signed zero, no flags.

Test Plan:
- Exact divide, 15/3: a=0x41700000, b=0x40400000, start at cycle 0 -> done in cycle 28 only, q=0x40A00000, flags=0; busy high cycles 1..27.
- Rounding, 1/3: a=0x3F800000, b=0x40400000 -> q=0x3EAAAAAB (RND=1). Repeated with RND=0 -> 0x3EAAAAAA. Sign case 5/-1: a=0x40A00000, b=0xBF800000 -> q=0xC0A00000.
- Specials:
  - 1/0 -> 0x7F800000, flags=0100.
  - 0/0 -> 0x7FC00000, flags=1000.
  - -0/5 -> 0x80000000.
  - 0x7F800000/0x40000000 -> 0x7F800000.
- Range:
  - 0x7F000000/0x3E800000 -> 0x7F800000, flags=0010.
  - 0x00800000/0x40000000 -> 0x00000000, flags=0001.
  - Subnormal a=0x00000001, b=0x3F800000 -> 0x00000000.
- Handshake: start pulsed again in cycles 5 and 20 with other operands -> ignored, single done. Start in the done cycle -> second done exactly 28 cycles later with the second result; q holds the first result in between.
- Reset: drive rst_n low asynchronously in cycle 10 -> busy/done/q/flags go to 0 immediately with no clock edge; no done afterward. A fresh start after release completes normally.
